uart: RTL and testbench
=======================

UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit period; legal range 1..65535.
REQ-002 Positional port order SHALL be: clk, load_byte, t_byte, rst, data, serial_out.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 load_byte  input  1  when high at a clk edge, data is captured into the holding register.
REQ-006 t_byte  input  1  when high at a clk edge in IDLE, starts transmission of one frame.
REQ-007 data  input  8  byte to be loaded.
REQ-008 serial_out  output  1  registered serial line; idle level 1.

Function
REQ-009 The holding register SHALL load data whenever load_byte=1, in any state; a load during a frame SHALL NOT alter the frame in flight.
REQ-010 States: IDLE, START, DATA, PARITY (only with UART_PARITY_EN), STOP.
REQ-011 In IDLE, t_byte=1 at edge N SHALL copy the holding register into the shift register, enter START, and drive serial_out=0 from edge N onward.
REQ-012 If load_byte and t_byte are both high at the same IDLE edge, the frame SHALL carry the new data value (bypass).
REQ-013 Each bit SHALL be held exactly CLKS_PER_BIT cycles: START bit 0, then DATA bits 0..7 LSB first, then STOP bit 1.
REQ-014 After the STOP period the FSM SHALL return to IDLE with serial_out=1; the frame is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-015 t_byte SHALL be ignored in every state other than IDLE; a level held high SHALL restart only once IDLE is re-entered.
REQ-016 t_byte without a prior load SHALL transmit the current holding value (0x00 after reset).
REQ-017 A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) SHALL both restart at each state entry.

Reset
REQ-018 rst=0 SHALL immediately and asynchronously force state IDLE, serial_out=1, and clear the holding register, shift register and all counters to 0, including in the middle of a frame.
REQ-019 After rst deasserts, the first rising edge SHALL evaluate load_byte/t_byte normally.

Configuration
REQ-020 Macro UART_PARITY_EN: when defined, a PARITY bit equal to the even parity (XOR of the 8 data bits) SHALL be sent for CLKS_PER_BIT cycles between DATA bit 7 and STOP; when undefined, the PARITY state and its logic SHALL not exist and DATA goes directly to STOP.

Structure
REQ-021 Package uart_pkg SHALL hold the state enum typedef and the default CLKS_PER_BIT constant.
REQ-022 Sub-module uart_baud_gen SHALL produce a one-cycle bit-end tick from the baud counter, restarted by the FSM at state entry.

Verification
REQ-023 Reset, load 0x55, t_byte 1 cycle -> serial_out 0,1,0,1,0,1,0,1,0,1 (start, 8 data LSB first, stop), each held 4 cycles, then idle 1.
REQ-024 Reset, load 0x2A, t_byte -> serial_out 0,0,1,0,1,0,1,0,0,1, each held 4 cycles, 40 cycles total.
REQ-025 rst=0 during DATA bit 3 of 0x55 -> serial_out=1 the same cycle, no further transitions; a later t_byte without load sends 0x00.
REQ-026 t_byte pulsed and load_byte 0xFF during a 0x55 frame -> frame still 0x55; a next t_byte after return to IDLE sends 0xFF.
REQ-027 With UART_PARITY_EN, send 0x07 -> parity bit 1 after data bit 7, frame 44 cycles; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
// Build option UART_PARITY_EN adds the PARITY state to the frame.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEF = 4;
    localparam int unsigned UART_BAUD_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick
// on the last cycle of each bit; i_restart holds the count at zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [UART_BAUD_W-1:0] LP_TC = UART_BAUD_W'(CLKS_PER_BIT - 1);

    logic [UART_BAUD_W-1:0] r_cnt;
    logic                   w_tc;

    assign w_tc   = (r_cnt == LP_TC);
    assign o_tick = w_tc & ~i_restart;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart.sv
// UART transmitter: holding register, shift register and frame FSM.
// Define UART_PARITY_EN to insert an even-parity bit between DATA and STOP.
//
// state     | meaning
// ST_IDLE   | line high, waiting for t_byte
// ST_START  | start bit (0)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity of the byte (UART_PARITY_EN only)
// ST_STOP   | stop bit (1), then back to IDLE
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       load_byte,
    input  logic       t_byte,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       serial_out
);

    uart_state_t r_state;
    logic [7:0]  r_hold;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        w_tick;
    logic        w_restart;

    // Every non-IDLE entry lands on a tick, where the counter wraps by itself;
    // only the IDLE->START entry needs an explicit restart.
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (load_byte) begin
            r_hold <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            serial_out <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    serial_out <= 1'b1;
                    if (t_byte) begin
                        r_shift    <= load_byte ? data : r_hold;
                        r_bit_cnt  <= '0;
                        serial_out <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_bit_cnt  <= '0;
                        serial_out <= r_shift[0];
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        // Rotate rather than shift so the byte survives for parity.
                        r_shift <= {r_shift[0], r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            serial_out <= even_parity(r_shift);
                            r_state    <= ST_PARITY;
`else
                            serial_out <= 1'b1;
                            r_state    <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            serial_out <= r_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_bit_cnt  <= '0;
                        serial_out <= 1'b1;
                        r_state    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_bit_cnt  <= '0;
                        serial_out <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_bit_cnt  <= '0;
                    serial_out <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for the uart transmitter (CLKS_PER_BIT = 4).
// Picks up UART_PARITY_EN to expect the extra parity bit.
`timescale 1ns/1ps
module tb_uart;

    localparam int C = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk       = 1'b0;
    logic       load_byte = 1'b0;
    logic       t_byte    = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] data      = 8'h00;
    logic       serial_out;

    int n_checks = 0;
    int n_fail   = 0;

    uart #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .load_byte (load_byte),
        .t_byte    (t_byte),
        .rst       (rst),
        .data      (data),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: serial_out=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for wire position idx of a frame carrying d (parity p).
    function automatic logic wire_bit(input logic [7:0] d, input logic p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (NB == 11 && idx == 9) return p;
        return 1'b1;
    endfunction

    task automatic load(input logic [7:0] v);
        load_byte = 1'b1;
        data      = v;
        @(negedge clk);
        load_byte = 1'b0;
        data      = 8'h00;
    endtask

    task automatic start_tx(input logic do_load, input logic [7:0] v);
        load_byte = do_load;
        data      = v;
        t_byte    = 1'b1;
        @(negedge clk);
        load_byte = 1'b0;
        data      = 8'h00;
        t_byte    = 1'b0;
    endtask

    // Called at the first negedge of the start bit; returns at the first idle negedge.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic p);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < C; c++) begin
                check_eq($sformatf("%s bit%0d cyc%0d", tag, b, c), serial_out, wire_bit(d, p, b));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_eq("reset_level", serial_out, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_after_reset", serial_out, 1'b1);

        // 0x55 -> 0,1,0,1,0,1,0,1,0,1
        load(8'h55);
        check_eq("load_no_tx", serial_out, 1'b1);
        start_tx(1'b0, 8'h00);
        expect_frame("f55", 8'h55, 1'b0);
        check_eq("f55_idle", serial_out, 1'b1);

        // 0x2A -> 0,0,1,0,1,0,1,0,0,1
        load(8'h2A);
        start_tx(1'b0, 8'h00);
        expect_frame("f2a", 8'h2A, 1'b1);
        check_eq("f2a_idle", serial_out, 1'b1);

        // load and t_byte on the same edge: frame carries the new byte
        start_tx(1'b1, 8'hA3);
        expect_frame("bypass_a3", 8'hA3, 1'b0);
        check_eq("bypass_idle", serial_out, 1'b1);

        // reset during data bit 3 of 0x55
        load(8'h55);
        start_tx(1'b0, 8'h00);
        repeat (4 * C + 1) @(negedge clk);
        check_eq("pre_rst_bit3", serial_out, 1'b0);
        #2 rst = 1'b0;
        #1 check_eq("rst_async", serial_out, 1'b1);
        t_byte = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_hold%0d", i), serial_out, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        t_byte = 1'b0;
        expect_frame("after_rst_00", 8'h00, 1'b0);
        check_eq("after_rst_idle", serial_out, 1'b1);

        // t_byte/load during a frame; t_byte held high across frame end
        load(8'h55);
        start_tx(1'b0, 8'h00);
        fork
            expect_frame("busy55", 8'h55, 1'b0);
            begin
                repeat (6) @(negedge clk);
                t_byte    = 1'b1;
                load_byte = 1'b1;
                data      = 8'hFF;
                @(negedge clk);
                t_byte    = 1'b0;
                load_byte = 1'b0;
                data      = 8'h00;
                repeat (C * NB - 10) @(negedge clk);
                t_byte = 1'b1;
            end
        join
        check_eq("relaunch_gap", serial_out, 1'b1);
        @(negedge clk);
        t_byte = 1'b0;
        expect_frame("next_ff", 8'hFF, 1'b0);
        check_eq("next_ff_idle", serial_out, 1'b1);

`ifdef UART_PARITY_EN
        load(8'h07);
        start_tx(1'b0, 8'h00);
        expect_frame("par07", 8'h07, 1'b1);
        check_eq("par07_idle", serial_out, 1'b1);
        load(8'h03);
        start_tx(1'b0, 8'h00);
        expect_frame("par03", 8'h03, 1'b0);
        check_eq("par03_idle", serial_out, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
